// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags each channel stalled for THRESH
// consecutive cycles and records the first channel to block plus the peak stall length.
module axis_stall_detector #(
  parameter int                NUM_CH   = 15,
  parameter int                THRESH   = 1024,
  parameter int                CNT_W    = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK = {NUM_CH{1'b0}},
  parameter int                IDX_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_ch,
  output logic [CNT_W-1:0]  max_stall
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

  state_e             r_state      [NUM_CH];
  logic [CNT_W-1:0]   r_cnt        [NUM_CH];
  logic [NUM_CH-1:0]  r_block;
  logic               r_any;
  logic               r_first_valid;
  logic [IDX_W-1:0]   r_first_ch;
  logic [CNT_W-1:0]   r_max;

  state_e             w_state_next [NUM_CH];
  logic [CNT_W-1:0]   w_cnt_next   [NUM_CH];
  logic [NUM_CH-1:0]  w_stall;
  logic [NUM_CH-1:0]  w_hs;
  logic [NUM_CH-1:0]  w_blk_next;
  logic [NUM_CH-1:0]  w_enter;
  logic [CNT_W-1:0]   w_max_next;
  logic [IDX_W-1:0]   w_first_idx;

  // Producer-side channels stall on a full sink, consumer-side on an empty source.
  assign w_stall = (DIR_MASK & tvalid & ~tready) | (~DIR_MASK & tready & ~tvalid);
  assign w_hs    = tvalid & tready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_next[i] = r_state[i];
      w_cnt_next[i]   = r_cnt[i];
      if (!enable) begin
        w_state_next[i] = ST_IDLE;
        w_cnt_next[i]   = '0;
      end else begin
        unique case (r_state[i])
          ST_IDLE: begin
            if (w_stall[i]) begin
              w_state_next[i] = (THRESH == 1) ? ST_BLOCKED : ST_COUNT;
              w_cnt_next[i]   = CNT_ONE;
            end else begin
              w_cnt_next[i]   = '0;
            end
          end
          ST_COUNT: begin
            if (w_hs[i] || !w_stall[i]) begin
              w_state_next[i] = ST_IDLE;
              w_cnt_next[i]   = '0;
            end else if (r_cnt[i] == THRESH_M1) begin
              w_state_next[i] = ST_BLOCKED;
              w_cnt_next[i]   = THRESH_C;
            end else begin
              w_cnt_next[i]   = r_cnt[i] + CNT_ONE;
            end
          end
          ST_BLOCKED: begin
            if (w_hs[i] || !w_stall[i]) begin
              w_state_next[i] = ST_IDLE;
              w_cnt_next[i]   = '0;
            end else if (r_cnt[i] != CNT_MAX) begin
              w_cnt_next[i]   = r_cnt[i] + CNT_ONE;
            end
          end
          default: begin
            w_state_next[i] = ST_IDLE;
            w_cnt_next[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_max_next  = r_max;
    w_first_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_blk_next[i] = (w_state_next[i] == ST_BLOCKED);
      w_enter[i]    = w_blk_next[i] && (r_state[i] != ST_BLOCKED);
      if (w_cnt_next[i] > w_max_next) w_max_next = w_cnt_next[i];
    end
    // Scanning downward leaves the lowest entering index as the winner.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_enter[i]) w_first_idx = IDX_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the per-channel counter arrays are flops, not RAM, so they are reset with everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_block       <= '0;
      r_any         <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_max         <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_block       <= '0;
      r_any         <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_max         <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_next[i];
        r_cnt[i]   <= w_cnt_next[i];
      end
      r_block <= w_blk_next;
      r_any   <= |w_blk_next;
      r_max   <= w_max_next;
      if (!r_first_valid && (|w_enter)) begin
        r_first_valid <= 1'b1;
        r_first_ch    <= w_first_idx;
      end
    end
  end

  assign axis_block_sigs = r_block;
  assign any_block       = r_any;
  assign first_valid     = r_first_valid;
  assign first_ch        = r_first_ch;
  assign max_stall       = r_max;

endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed self-checking bench for axis_stall_detector with THRESH=4 and ch0 on the producer side.
module tb_axis_stall_detector;

  localparam int NUM_CH = 15;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 4;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] tvalid;
  logic [NUM_CH-1:0] tready;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_valid;
  logic [IDX_W-1:0]  first_ch;
  logic [CNT_W-1:0]  max_stall;

  int compared   = 0;
  int mismatched = 0;

  axis_stall_detector #(
    .NUM_CH   (NUM_CH),
    .THRESH   (4),
    .CNT_W    (CNT_W),
    .DIR_MASK (15'h0001),
    .IDX_W    (IDX_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .tvalid          (tvalid),
    .tready          (tready),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .max_stall       (max_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] blk, input logic [31:0] any,
                           input logic [31:0] fv, input logic [31:0] fc, input logic [31:0] mx);
    check({tag, ".blk"},   32'(axis_block_sigs), blk);
    check({tag, ".any"},   32'(any_block),       any);
    check({tag, ".fv"},    32'(first_valid),     fv);
    check({tag, ".fch"},   32'(first_ch),        fc);
    check({tag, ".max"},   32'(max_stall),       mx);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    tvalid = '0;
    tready = '0;
    #2 reset = 1'b0;
    #1;
    check_all("reset", 32'h0, 0, 0, 0, 0);
    cyc(2);
    reset  = 1'b1;
    enable = 1'b1;
    cyc(1);
    check_all("idle", 32'h0, 0, 0, 0, 0);

    // ch2 consumer side starved for 6 cycles
    tready[2] = 1'b1;
    cyc(3);
    check_all("t1_c3", 32'h0, 0, 0, 0, 3);
    cyc(1);
    check_all("t1_c4", 32'h0004, 1, 1, 2, 4);
    cyc(2);
    check_all("t1_c6", 32'h0004, 1, 1, 2, 6);
    tready[2] = 1'b0;
    cyc(1);
    check_all("t1_rel", 32'h0, 0, 1, 2, 6);
    pulse_clear();
    check_all("t1_clr", 32'h0, 0, 0, 0, 0);

    // ch0 producer side: a handshake in the middle breaks the run
    tvalid[0] = 1'b1;
    cyc(3);
    check_all("t2_a", 32'h0, 0, 0, 0, 3);
    tready[0] = 1'b1;
    cyc(1);
    check_all("t2_hs", 32'h0, 0, 0, 0, 3);
    tready[0] = 1'b0;
    cyc(3);
    check_all("t2_b", 32'h0, 0, 0, 0, 3);
    tvalid[0] = 1'b0;
    pulse_clear();

    // ch0 is producer side, so an empty-source pattern is not a stall there
    tready[0] = 1'b1;
    cyc(5);
    check_all("t2_dir", 32'h0, 0, 0, 0, 0);
    tready[0] = 1'b0;
    pulse_clear();

    // ch5 and ch9 block together; lowest index wins and stays after ch9 unblocks
    tready[5] = 1'b1;
    tready[9] = 1'b1;
    cyc(3);
    check_all("t3_c3", 32'h0, 0, 0, 0, 3);
    cyc(1);
    check_all("t3_c4", 32'h0220, 1, 1, 5, 4);
    tvalid[9] = 1'b1;
    cyc(1);
    check_all("t3_un9", 32'h0020, 1, 1, 5, 5);
    tready = '0;
    tvalid = '0;
    cyc(1);
    check_all("t3_rel", 32'h0, 0, 1, 5, 5);
    pulse_clear();

    // ch3 blocks, one handshake drops the flag, then clear wipes everything
    tready[3] = 1'b1;
    cyc(4);
    check_all("t4_blk", 32'h0008, 1, 1, 3, 4);
    tvalid[3] = 1'b1;
    cyc(1);
    check_all("t4_hs", 32'h0, 0, 1, 3, 4);
    tvalid[3] = 1'b0;
    tready[3] = 1'b0;
    clear     = 1'b1;
    cyc(1);
    clear     = 1'b0;
    check_all("t4_clr", 32'h0, 0, 0, 0, 0);

    // async reset mid-stall on ch1, then a fresh THRESH-cycle count
    tready[1] = 1'b1;
    cyc(2);
    check("t5_pre.max", 32'(max_stall), 32'd2);
    #2 reset = 1'b0;
    #1;
    check_all("t5_rst", 32'h0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(3);
    check_all("t5_c3", 32'h0, 0, 0, 0, 3);
    cyc(1);
    check_all("t5_c4", 32'h0002, 1, 1, 1, 4);
    tready[1] = 1'b0;
    pulse_clear();

    // enable low while ch4 is blocked, then resume with the stall still present
    tready[4] = 1'b1;
    cyc(4);
    check_all("t6_blk", 32'h0010, 1, 1, 4, 4);
    enable = 1'b0;
    cyc(1);
    check_all("t6_dis", 32'h0, 0, 1, 4, 4);
    cyc(2);
    check_all("t6_dis2", 32'h0, 0, 1, 4, 4);
    enable = 1'b1;
    cyc(3);
    check_all("t6_en3", 32'h0, 0, 1, 4, 4);
    cyc(1);
    check_all("t6_en4", 32'h0010, 1, 1, 4, 4);
    cyc(2);
    check_all("t6_en6", 32'h0010, 1, 1, 4, 6);
    tready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
